// File: rtl/vadd_pair_ctl.sv
// ---------------------------------------------------------------------------
// vadd_pair_ctl
//   Sequencing controller for one even/odd vadd pair. It takes an operation
//   from dispatch, launches the pair with a one-cycle start pulse, and collects
//   both partial sums in either order. It then adds them into a 64-bit result
//   and reports done, exception bits and a watchdog timeout.
//
// Ports
//   clk, reset            core clock, async active-high reset
//   disp_start            operation request (accepted only in IDLE)
//   disp_last_offst[47:0] byte offset of last element, captured on accept
//   tmo_limit[TMO_W-1:0]  WAIT-state cycle limit, 0 = watchdog off
//   sum_e/o[63:0]         partial sums from even/odd unit
//   sum_vld_e/o           partial-sum valid pulses
//   sum_ovrflw_e/o        unit sum overflow (qualified by sum_vld)
//   res_ovrflw_e/o        unit result overflow (qualified by sum_vld)
//   start                 one-cycle launch pulse to the pair
//   idle / busy           IDLE indication and its complement
//   mem_last_offst[47:0]  registered offset to the pair
//   done                  one-cycle completion pulse
//   total_sum[63:0]       final result, held until next accept
//   exc[3:0]              {timeout, combine ovf, res ovf, sum ovf}
// ---------------------------------------------------------------------------
module vadd_pair_ctl #(
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             disp_start,
  input  logic [47:0]      disp_last_offst,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic [63:0]      sum_e,
  input  logic [63:0]      sum_o,
  input  logic             sum_vld_e,
  input  logic             sum_vld_o,
  input  logic             sum_ovrflw_e,
  input  logic             sum_ovrflw_o,
  input  logic             res_ovrflw_e,
  input  logic             res_ovrflw_o,
  output logic             start,
  output logic             idle,
  output logic [47:0]      mem_last_offst,
  output logic             busy,
  output logic             done,
  output logic [63:0]      total_sum,
  output logic [3:0]       exc
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_COMBINE, S_DONE
  } state_t;

  state_t state_q, state_d;

  // registered control outputs
  logic start_q, start_d;
  logic idle_q,  idle_d;
  logic busy_q,  busy_d;
  logic done_q,  done_d;

  // datapath state
  logic [47:0]      offst_q, offst_d;
  logic [63:0]      sum_e_q, sum_e_d;
  logic [63:0]      sum_o_q, sum_o_d;
  logic             got_e_q, got_e_d;
  logic             got_o_q, got_o_d;
  logic [TMO_W-1:0] cnt_q,   cnt_d;
  logic [63:0]      total_q, total_d;
  logic [3:0]       exc_q,   exc_d;

  logic        accept, in_wait, take_e, take_o, both_got, tmo_hit;
  logic [63:0] add_sum;
  logic        add_ovf;

  assign accept  = (state_q == S_IDLE) && disp_start;
  assign in_wait = (state_q == S_WAIT);

  // Only the first valid from each unit counts; repeats are dropped.
  assign take_e   = in_wait && sum_vld_e && !got_e_q;
  assign take_o   = in_wait && sum_vld_o && !got_o_q;
  assign both_got = (got_e_q || take_e) && (got_o_q || take_o);

  // Completion in the same cycle as the limit beats the timeout.
  assign tmo_hit  = in_wait && (tmo_limit != '0) &&
                    (cnt_q == tmo_limit - TMO_W'(1)) && !both_got;

  assign add_sum = sum_e_q + sum_o_q;
  assign add_ovf = (sum_e_q[63] == sum_o_q[63]) && (add_sum[63] != sum_e_q[63]);

  // ---- state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (disp_start) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (both_got)     state_d = S_COMBINE;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_COMBINE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---- output logic: decoded from next state so the outputs are registered ----
  always_comb begin
    start_d = (state_d == S_LAUNCH);
    idle_d  = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // ---- datapath next state ----
  always_comb begin
    offst_d = offst_q;
    sum_e_d = sum_e_q;
    sum_o_d = sum_o_q;
    got_e_d = got_e_q;
    got_o_d = got_o_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    exc_d   = exc_q;

    if (accept) begin
      offst_d = disp_last_offst;
      got_e_d = 1'b0;
      got_o_d = 1'b0;
      cnt_d   = '0;
      total_d = '0;
      exc_d   = '0;
    end

    if (in_wait) begin
      cnt_d = cnt_q + TMO_W'(1);
      if (take_e) begin
        sum_e_d  = sum_e;
        got_e_d  = 1'b1;
        exc_d[0] = exc_d[0] | sum_ovrflw_e;
        exc_d[1] = exc_d[1] | res_ovrflw_e;
      end
      if (take_o) begin
        sum_o_d  = sum_o;
        got_o_d  = 1'b1;
        exc_d[0] = exc_d[0] | sum_ovrflw_o;
        exc_d[1] = exc_d[1] | res_ovrflw_o;
      end
      if (tmo_hit) begin
        exc_d[3] = 1'b1;
        total_d  = '0;
      end
    end

    if (state_q == S_COMBINE) begin
      total_d  = add_sum;
      exc_d[2] = add_ovf;
    end
  end

  // ---- registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      offst_q <= '0;
      sum_e_q <= '0;
      sum_o_q <= '0;
      got_e_q <= 1'b0;
      got_o_q <= 1'b0;
      cnt_q   <= '0;
      total_q <= '0;
      exc_q   <= '0;
    end else begin
      start_q <= start_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      offst_q <= offst_d;
      sum_e_q <= sum_e_d;
      sum_o_q <= sum_o_d;
      got_e_q <= got_e_d;
      got_o_q <= got_o_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      exc_q   <= exc_d;
    end
  end

  assign start          = start_q;
  assign idle           = idle_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_last_offst = offst_q;
  assign total_sum      = total_q;
  assign exc            = exc_q;

endmodule

// File: tb/tb_vadd_pair_ctl.sv
module tb_vadd_pair_ctl;
  localparam int TMO_W = 20;

  logic             clk, reset, disp_start;
  logic [47:0]      disp_last_offst;
  logic [TMO_W-1:0] tmo_limit;
  logic [63:0]      sum_e, sum_o;
  logic             sum_vld_e, sum_vld_o;
  logic             sum_ovrflw_e, sum_ovrflw_o, res_ovrflw_e, res_ovrflw_o;
  logic             start, idle, busy, done;
  logic [47:0]      mem_last_offst;
  logic [63:0]      total_sum;
  logic [3:0]       exc;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done;

  vadd_pair_ctl #(.TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .disp_start(disp_start),
    .disp_last_offst(disp_last_offst), .tmo_limit(tmo_limit),
    .sum_e(sum_e), .sum_o(sum_o), .sum_vld_e(sum_vld_e), .sum_vld_o(sum_vld_o),
    .sum_ovrflw_e(sum_ovrflw_e), .sum_ovrflw_o(sum_ovrflw_o),
    .res_ovrflw_e(res_ovrflw_e), .res_ovrflw_o(res_ovrflw_o),
    .start(start), .idle(idle), .mem_last_offst(mem_last_offst), .busy(busy),
    .done(done), .total_sum(total_sum), .exc(exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive disp_start for one cycle; returns in cycle T+1
  task automatic accept(input logic [47:0] offs);
    disp_last_offst = offs;
    disp_start      = 1'b1;
    tick();
    disp_start      = 1'b0;
  endtask

  task automatic drv_e(input logic [63:0] v, input logic so, input logic ro);
    sum_vld_e = 1'b1; sum_e = v; sum_ovrflw_e = so; res_ovrflw_e = ro;
  endtask

  task automatic drv_o(input logic [63:0] v, input logic so, input logic ro);
    sum_vld_o = 1'b1; sum_o = v; sum_ovrflw_o = so; res_ovrflw_o = ro;
  endtask

  task automatic clr_vld();
    sum_vld_e = 1'b0; sum_vld_o = 1'b0;
    sum_ovrflw_e = 1'b0; sum_ovrflw_o = 1'b0;
    res_ovrflw_e = 1'b0; res_ovrflw_o = 1'b0;
  endtask

  // both sums in the first WAIT cycle (T+2) -> done at T+4
  task automatic fast_op(input string tag, input logic [63:0] e, input logic se, input logic re,
                         input logic [63:0] o, input logic so, input logic ro,
                         input logic [63:0] exp_sum, input logic [3:0] exp_exc);
    accept(48'h100);
    chk({tag, "_clr_sum"}, total_sum, 64'h0);
    chk({tag, "_clr_exc"}, exc, 4'h0);
    tick();                              // T+2
    drv_e(e, se, re);
    drv_o(o, so, ro);
    tick();                              // T+3
    clr_vld();
    chk({tag, "_done_early"}, done, 1'b0);
    tick();                              // T+4
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_sum"}, total_sum, exp_sum);
    chk({tag, "_exc"}, exc, exp_exc);
    tick();                              // T+5
    chk({tag, "_idle"}, idle, 1'b1);
  endtask

  initial begin
    reset = 1'b1; disp_start = 1'b0; disp_last_offst = '0; tmo_limit = '0;
    sum_e = '0; sum_o = '0;
    clr_vld();

    // ---- reset state ----
    tick(); tick();
    chk("rst_start", start, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_offst", mem_last_offst, 48'h0);
    chk("rst_sum", total_sum, 64'h0);
    chk("rst_exc", exc, 4'h0);
    reset = 1'b0;
    tick();

    // ---- basic, with an ignored disp_start during WAIT ----
    accept(48'h1F8);                     // T+1
    chk("basic_start", start, 1'b1);
    chk("basic_idle", idle, 1'b0);
    chk("basic_busy", busy, 1'b1);
    chk("basic_offst", mem_last_offst, 48'h1F8);
    tick();                              // T+2
    chk("basic_start_1cyc", start, 1'b0);
    tick();                              // T+3 (WAIT)
    disp_last_offst = 48'hABC;
    disp_start = 1'b1;
    tick();                              // T+4
    disp_start = 1'b0;
    chk("ign_start", start, 1'b0);
    chk("ign_offst", mem_last_offst, 48'h1F8);
    drv_e(64'd5, 1'b0, 1'b0);
    tick();                              // T+5
    clr_vld();
    tick();                              // T+6
    drv_o(64'd7, 1'b0, 1'b0);
    tick();                              // T+7
    clr_vld();
    chk("basic_done_early", done, 1'b0);
    tick();                              // T+8
    chk("basic_done", done, 1'b1);
    chk("basic_sum", total_sum, 64'd12);
    chk("basic_exc", exc, 4'h0);
    tick();                              // T+9
    chk("basic_done_1cyc", done, 1'b0);
    chk("basic_idle_back", idle, 1'b1);
    chk("basic_sum_hold", total_sum, 64'd12);

    // ---- back-to-back accept; odd before even ----
    accept(48'h40);                      // T+1
    chk("b2b_start", start, 1'b1);
    tick();                              // T+2
    drv_o(64'd3, 1'b0, 1'b0);
    tick();                              // T+3
    clr_vld();
    drv_e(64'd10, 1'b0, 1'b0);
    tick();                              // T+4
    clr_vld();
    chk("order_done_early", done, 1'b0);
    tick();                              // T+5
    chk("order_done", done, 1'b1);
    chk("order_sum", total_sum, 64'd13);
    tick();

    // ---- repeated sum_vld_e ignored, then both valid in the same cycle ----
    accept(48'h80);                      // T+1
    tick();                              // T+2
    drv_e(64'd20, 1'b0, 1'b0);
    tick();                              // T+3
    drv_e(64'd99, 1'b1, 1'b1);
    tick();                              // T+4 = W
    drv_e(64'd99, 1'b1, 1'b1);
    drv_o(64'd22, 1'b0, 1'b0);
    tick();                              // W+1
    clr_vld();
    chk("rep_done_early", done, 1'b0);
    tick();                              // W+2
    chk("rep_done", done, 1'b1);
    chk("rep_sum", total_sum, 64'd42);
    chk("rep_exc", exc, 4'h0);
    tick();

    // ---- simultaneous and overflow cases ----
    fast_op("simul", 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, 64'd3, 4'b0000);
    fast_op("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd1, 1'b0, 1'b1,
            64'h8000_0000_0000_0000, 4'b0110);
    fast_op("negovf", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
            64'h0, 4'b0101);
    fast_op("negok", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd1, 1'b0, 1'b0, 64'h0, 4'b0000);

    // ---- watchdog timeout, limit 16, only even arrives ----
    tmo_limit = 20'd16;
    accept(48'h200);                     // T+1
    tick();                              // T+2
    tick();                              // T+3
    drv_e(64'd5, 1'b0, 1'b0);
    tick();                              // T+4
    clr_vld();
    for (int i = 0; i < 13; i++) tick(); // T+17
    chk("tmo_done_early", done, 1'b0);
    tick();                              // T+18
    chk("tmo_done", done, 1'b1);
    chk("tmo_exc", exc, 4'b1000);
    chk("tmo_sum", total_sum, 64'h0);
    tick();

    // ---- completion coincides with the limit: completion wins ----
    tmo_limit = 20'd4;
    accept(48'h204);                     // T+1
    tick();                              // T+2
    drv_e(64'd1, 1'b0, 1'b0);
    tick();                              // T+3
    clr_vld();
    tick();                              // T+4
    tick();                              // T+5, counter at limit-1
    drv_o(64'd2, 1'b0, 1'b0);
    tick();                              // T+6
    clr_vld();
    chk("coin_done_early", done, 1'b0);
    tick();                              // T+7
    chk("coin_done", done, 1'b1);
    chk("coin_exc", exc, 4'h0);
    chk("coin_sum", total_sum, 64'd3);
    tick();

    // ---- watchdog disabled: stays in WAIT ----
    tmo_limit = '0;
    accept(48'h300);
    tick();
    drv_e(64'd1, 1'b0, 1'b0);
    tick();
    clr_vld();
    n_done = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    chk("notmo_no_done", n_done, 0);
    chk("notmo_busy", busy, 1'b1);

    // ---- async reset mid-WAIT ----
    reset = 1'b1;
    #1;
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_offst", mem_last_offst, 48'h0);
    chk("mid_rst_exc", exc, 4'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_done", done, 1'b0);

    // ---- fresh operation after reset ----
    accept(48'h10);
    chk("fresh_offst", mem_last_offst, 48'h10);
    tick();                              // T+2
    drv_e(64'd4, 1'b0, 1'b0);
    drv_o(64'd6, 1'b0, 1'b0);
    tick();
    clr_vld();
    tick();                              // T+4
    chk("fresh_done", done, 1'b1);
    chk("fresh_sum", total_sum, 64'd10);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vadd_pair_ctl.md
# vadd_pair_ctl

Sequencing controller for one vadd_pair (even/odd vadd units sharing start, idle and mem_last_offst). It accepts an operation from dispatch, pulses start to the pair, and collects each unit's partial sum and overflow flags in either order. It then forms the final 64-bit result and reports completion, exception bits and a watchdog timeout back to dispatch.

## Interface
- TMO_W, 20, width of the watchdog counter and tmo_limit
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- disp_start  in  1  one-cycle operation request; accepted only in IDLE
- disp_last_offst  in  48  byte offset of last element; captured on accept
- tmo_limit  in  TMO_W  WAIT-state cycle limit; 0 disables the watchdog
- sum_e / sum_o  in  64  partial sum from even/odd unit
- sum_vld_e / sum_vld_o  in  1  partial-sum valid pulse, even/odd
- sum_ovrflw_e / sum_ovrflw_o  in  1  unit sum overflow, qualified by matching sum_vld
- res_ovrflw_e / res_ovrflw_o  in  1  unit result overflow, qualified by matching sum_vld
- start  out  1  one-cycle launch pulse to the pair
- idle  out  1  high only in IDLE; drives pair idle
- mem_last_offst  out  48  registered offset to the pair
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- total_sum  out  64  final result; valid from done until next accept
- exc  out  4  [0] sum_ovrflw_e|o, [1] res_ovrflw_e|o, [2] combine overflow, [3] timeout

## Operation
- States: IDLE, LAUNCH, WAIT, COMBINE, DONE. All outputs registered.
- IDLE: disp_start=1 -> capture disp_last_offst into mem_last_offst, clear total_sum, exc, both got_e/got_o flags and tmo counter; go LAUNCH.
- LAUNCH: start=1 for exactly this cycle; go WAIT.
- WAIT: on sum_vld_x with got_x=0, latch sum_x, OR sum_ovrflw_x into exc[0] and res_ovrflw_x into exc[1], set got_x. A second sum_vld_x while got_x=1 is ignored (no relatch, no flag update). Both units may be valid in the same cycle.
- WAIT exit: when both got flags are set (including flags set this cycle), go COMBINE.
- Watchdog: counter increments each WAIT cycle. If tmo_limit!=0, counter==tmo_limit-1 and the exit condition is not met -> exc[3]=1, total_sum=0, go DONE (skip COMBINE). If completion and the limit coincide, completion wins and there is no timeout.
- COMBINE: total_sum <= sum_e_q + sum_o_q, modulo 2^64. exc[2] is set on two's-complement signed overflow (operand signs equal, result sign differs). Go DONE.
- DONE: done=1 for one cycle; go IDLE.
- disp_start outside IDLE is ignored (not queued). sum_vld in IDLE, LAUNCH, COMBINE or DONE is ignored.
- total_sum, exc and mem_last_offst hold until the next accepted disp_start.

## Timing
- Reset (async assert): IDLE; start=0, idle=1, busy=0, done=0, mem_last_offst=0, total_sum=0, exc=0, internal flags and counter=0. Reset mid-operation aborts with no done pulse.
- Accept at cycle T: start=1, idle=0, busy=1 and mem_last_offst valid in T+1.
- Last partial sum captured at cycle W: COMBINE in W+1, done=1 with total_sum/exc valid in W+2, idle=1 in W+3.
- Minimum accept-to-done with both sums at T+2: done at T+4.
- Timeout: WAIT entered at T+2; with no completion, done=1 at T+2+tmo_limit.
- Back-to-back: disp_start is accepted in the first IDLE cycle after DONE.

## Test plan
- Basic: accept offset 0x1F8, sum_e=5 at T+4, sum_o=7 at T+6 -> start only at T+1, mem_last_offst=0x1F8, done at T+8, total_sum=12, exc=0.
- Order/simultaneous: sum_o before sum_e; then both vld same cycle W -> done at W+2, sums correct; repeated sum_vld_e=99 after first is ignored.
- Flags/overflow: sum_e=0x7FFF_FFFF_FFFF_FFFF, sum_o=1, res_ovrflw_o=1 -> total_sum=0x8000_0000_0000_0000, exc=4'b0110.
- Watchdog: tmo_limit=16, only sum_e arrives -> done at T+18, exc[3]=1, total_sum=0. tmo_limit=0 -> no done after 10000 cycles.
- Ignored start: disp_start during WAIT -> no second start pulse, mem_last_offst unchanged.
- Reset mid-WAIT: assert reset -> idle=1, busy=0, all outputs 0 immediately, no done; a fresh operation then completes normally.
